// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot ring pointer, registered one-hot grant
// and a bounded tenure that preempts an owner while others are waiting.
module ring_rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         gnt_valid,
  output logic [N-1:0] ptr,
  output logic         timeout
);

  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  // Handshake: a requester raises req[i] and holds it for its whole tenure;
  // gnt[i] answers on the following edge and stays until req[i] drops or
  // the tenure limit hands the resource to a waiting requester.

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
  logic [N-1:0]  next_start;
  logic [N-1:0]  others;

  // First set bit of mask, scanning circularly upward from one-hot start.
  function automatic logic [N-1:0] win(input logic [N-1:0] start,
                                       input logic [N-1:0] mask);
    logic [N-1:0] res;
    logic         found;
    int           j;
    res   = '0;
    found = 1'b0;
    for (int s = 0; s < N; s++) begin
      if (start[s]) begin
        for (int i = 0; i < N; i++) begin
          j = (s + i) % N;
          if (!found && mask[j]) begin
            res[j] = 1'b1;
            found  = 1'b1;
          end
        end
      end
    end
    return res;
  endfunction

  assign next_start = {gnt_q[N-2:0], gnt_q[N-1]};
  assign others     = req & ~gnt_q;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && (req != '0)) begin
          gnt_d   = win(ptr_q, req);
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if ((req & gnt_q) == '0) begin
          ptr_d = next_start;
          cnt_d = '0;
          if (en && (req != '0)) begin
            gnt_d = win(next_start, req);
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end else if ((cnt_q == CNT_MAX) && (others != '0) && en) begin
          ptr_d     = next_start;
          gnt_d     = win(next_start, others);
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      ptr_q     <= {{(N-1){1'b0}}, 1'b1};
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // BUSY is exactly the gnt_valid state, so the FSM is visible on that port.
  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign ptr       = ptr_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Bench for ring_rr_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an index-based owner model.
module tb_ring_rr_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic         clk;
  logic         rst;
  logic         en;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [N-1:0] ptr;
  logic         timeout;

  int checks = 0;
  int errors = 0;

  ring_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt), .gnt_valid(gnt_valid), .ptr(ptr), .timeout(timeout)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // owner index (-1 = none), pointer index, cycles owned so far
  int m_owner;
  int m_ptr;
  int m_tenure;
  bit m_timeout;

  function automatic int win_idx(input int start, input logic [N-1:0] m);
    for (int i = 0; i < N; i++) begin
      if (m[(start + i) % N]) return (start + i) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owner = -1; m_ptr = 0; m_tenure = 0; m_timeout = 0;
    end else begin
      logic [N-1:0] mask;
      m_timeout = 0;
      if (m_owner < 0) begin
        if (en && req != '0) begin
          m_owner = win_idx(m_ptr, req); m_tenure = 1;
        end
      end else if (!req[m_owner]) begin
        m_ptr = (m_owner + 1) % N;
        if (en && req != '0) begin
          m_owner = win_idx(m_ptr, req); m_tenure = 1;
        end else begin
          m_owner = -1;
        end
      end else begin
        mask = req;
        mask[m_owner] = 1'b0;
        if (m_tenure == MAX_HOLD && en && mask != '0) begin
          m_ptr = (m_owner + 1) % N;
          m_owner = win_idx(m_ptr, mask); m_tenure = 1; m_timeout = 1;
        end else if (m_tenure < MAX_HOLD) begin
          m_tenure++;
        end
      end
    end
  end

  function automatic logic [N-1:0] exp_gnt();
    return (m_owner < 0) ? '0 : N'(1) << m_owner;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle model comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("model_gnt", 32'(gnt), 32'(exp_gnt()));
      chk("model_ptr", 32'(ptr), 32'(N'(1) << m_ptr));
      chk("model_timeout", 32'(timeout), 32'(m_timeout));
      chk("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
      chk("onehot_gnt", 32'($countones(gnt) <= 1), 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; en = 1'b1; req = '0;
    #12;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(gnt_valid), 32'h0);
    chk("rst_ptr", 32'(ptr), 32'h1);
    chk("rst_timeout", 32'(timeout), 32'h0);
    tick();
    rst = 1'b1;

    // single request
    req = 4'b0100; tick();
    chk("single_gnt", 32'(gnt), 32'h4);
    req = 4'b0000; tick();
    chk("single_rel_gnt", 32'(gnt), 32'h0);
    chk("single_rel_ptr", 32'(ptr), 32'h8);

    // pulse between edges is ignored
    #2 req = 4'b0100; #3 req = 4'b0000;
    tick();
    chk("glitch_ignored", 32'(gnt), 32'h0);

    // fair rotation, zero-bubble handoff
    pulse_reset();
    req = 4'b1111; tick();
    for (int k = 0; k < N; k++) begin
      chk("rot_first", 32'(gnt), 32'(1 << k));
      tick();
      chk("rot_hold", 32'(gnt), 32'(1 << k));
      req = 4'b1111 & ~(4'b0001 << k);
      tick();
      req = 4'b1111;
    end
    chk("rot_wrap", 32'(gnt), 32'h1);

    // preemption
    pulse_reset();
    req = 4'b0011; tick();
    for (int i = 0; i < MAX_HOLD; i++) begin
      chk("pre_own0", 32'(gnt), 32'h1);
      chk("pre_own0_to", 32'(timeout), 32'h0);
      tick();
    end
    chk("pre_gnt1", 32'(gnt), 32'h2);
    chk("pre_to1", 32'(timeout), 32'h1);
    chk("pre_ptr1", 32'(ptr), 32'h2);
    for (int i = 1; i < MAX_HOLD; i++) begin
      tick();
      chk("pre_own1", 32'(gnt), 32'h2);
      chk("pre_own1_to", 32'(timeout), 32'h0);
    end
    tick();
    chk("pre_gnt0", 32'(gnt), 32'h1);
    chk("pre_to0", 32'(timeout), 32'h1);

    // lone hog never times out
    pulse_reset();
    req = 4'b0001;
    for (int i = 0; i < 30; i++) tick();
    chk("hog_gnt", 32'(gnt), 32'h1);
    chk("hog_ptr", 32'(ptr), 32'h1);

    // wrap and enable
    pulse_reset();
    req = 4'b0100; tick();
    chk("wrap_own2", 32'(gnt), 32'h4);
    en = 1'b0; req = 4'b1011; tick();
    chk("wrap_idle", 32'(gnt), 32'h0);
    chk("wrap_ptr", 32'(ptr), 32'h8);
    en = 1'b1; tick();
    chk("wrap_own3", 32'(gnt), 32'h8);
    req = 4'b0011; tick();
    chk("wrap_own0", 32'(gnt), 32'h1);

    // asynchronous reset mid-tenure
    tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'h0);
    chk("arst_valid", 32'(gnt_valid), 32'h0);
    chk("arst_ptr", 32'(ptr), 32'h1);
    chk("arst_timeout", 32'(timeout), 32'h0);
    #3 rst = 1'b1;
    req = 4'b0010; tick();
    chk("arst_restart", 32'(gnt), 32'h2);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        if (req[b]) begin
          if ($urandom_range(0, 9) == 0) req[b] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req[b] = 1'b1;
        end
      end
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 299) == 0) pulse_reset();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
